// File: rtl/img_tx_pkg.sv
// Shared types and defaults for the image transmit scheduler.
package img_tx_pkg;

   localparam int unsigned ADDR_W_DEF = 14;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      START,
      WAIT_BUSY,
      SENDING,
      DONE
   } sched_state;

   // Width of a counter that must hold values 0..n-1 (never below 1 bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/img_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request after the last granted index.
module rr_arbiter #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_idx,
   output logic [NUM_SRC-1:0] o_gnt_c,
   output logic [IDX_W-1:0]   o_idx_c,
   output logic               o_any_c
);

   int unsigned      w_cand;
   logic [IDX_W-1:0] w_cand_idx;

   // Scan last+1 .. last+NUM_SRC (mod NUM_SRC); the first hit wins.
   always_comb begin
      o_gnt_c    = '0;
      o_idx_c    = '0;
      o_any_c    = 1'b0;
      w_cand     = 0;
      w_cand_idx = '0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         w_cand = 32'(i_last_idx) + k;
         if (w_cand >= NUM_SRC) w_cand = w_cand - NUM_SRC;
         w_cand_idx = IDX_W'(w_cand);
         if (!o_any_c && i_req[w_cand_idx]) begin
            o_any_c             = 1'b1;
            o_idx_c             = w_cand_idx;
            o_gnt_c[w_cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/img_tx_scheduler.sv
// Shares one UART image sender between NUM_SRC image buffers, one whole image per grant,
// round-robin, with start-pulse retry when the sender does not respond.
module img_tx_scheduler
   import img_tx_pkg::*;
#(
   parameter int unsigned NUM_SRC       = 4,
   parameter int unsigned ADDR_W        = ADDR_W_DEF,
   parameter int unsigned START_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst_in_n,
   input  logic [NUM_SRC-1:0]     req_in,
   output logic                   sender_start,
   input  logic                   sender_busy,
   input  logic [ADDR_W-1:0]      sender_addr,
   output logic [7:0]             sender_data,
   output logic [ADDR_W-1:0]      bram_addr,
   input  logic [8*NUM_SRC-1:0]   bram_data,
   output logic [NUM_SRC-1:0]     grant,
   output logic [NUM_SRC-1:0]     done,
   output logic [15:0]            frames_sent
);

   localparam int unsigned IDX_W = $clog2(NUM_SRC);
   localparam int unsigned CNT_W = cnt_width(START_TIMEOUT);
   localparam int unsigned SEL_W = IDX_W + 3;

   sched_state           r_state;
   sched_state           w_next_state;
   logic [NUM_SRC-1:0]   r_pending;
   logic [NUM_SRC-1:0]   r_grant;
   logic [IDX_W-1:0]     r_gnt_idx;
   logic [IDX_W-1:0]     r_last_idx;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_start;
   logic [NUM_SRC-1:0]   r_done;
   logic [7:0]           r_data;
   logic [15:0]          r_frames;

   logic [NUM_SRC-1:0]   w_arb_gnt;
   logic [IDX_W-1:0]     w_arb_idx;
   logic                 w_arb_any;
   logic [NUM_SRC-1:0]   w_pend_clr;
   logic [7:0]           w_sel_data;
   logic                 w_timeout;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req      (r_pending),
      .i_last_idx (r_last_idx),
      .o_gnt_c    (w_arb_gnt),
      .o_idx_c    (w_arb_idx),
      .o_any_c    (w_arb_any)
   );

   assign bram_addr    = sender_addr;
   assign sender_start = r_start;
   assign sender_data  = r_data;
   assign grant        = r_grant;
   assign done         = r_done;
   assign frames_sent  = r_frames;

   assign w_timeout  = (r_cnt == CNT_W'(START_TIMEOUT - 1));
   assign w_pend_clr = (r_state == DONE) ? r_grant : '0;
   assign w_sel_data = bram_data[SEL_W'({r_gnt_idx, 3'b000}) +: 8];

   // Next-state logic; stale sender_busy in IDLE/ARB has no effect.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:      if (|r_pending) w_next_state = ARB;
         ARB:       w_next_state = w_arb_any ? START : IDLE;
         START:     w_next_state = WAIT_BUSY;
         WAIT_BUSY: begin
            if (sender_busy)    w_next_state = SENDING;
            else if (w_timeout) w_next_state = START;
         end
         SENDING:   if (!sender_busy) w_next_state = DONE;
         DONE:      w_next_state = IDLE;
         default:   w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_state    <= IDLE;
         r_pending  <= '0;
         r_grant    <= '0;
         r_gnt_idx  <= '0;
         r_last_idx <= IDX_W'(NUM_SRC - 1);
         r_cnt      <= '0;
         r_start    <= 1'b0;
         r_done     <= '0;
         r_data     <= '0;
         r_frames   <= '0;
      end else begin
         r_state <= w_next_state;
         // A request landing in the DONE cycle re-queues the source.
         r_pending <= (r_pending & ~w_pend_clr) | req_in;
         r_start   <= (w_next_state == START);
         r_done    <= ((r_state == SENDING) && (w_next_state == DONE)) ? r_grant : '0;

         if ((r_state == ARB) && w_arb_any) begin
            r_grant    <= w_arb_gnt;
            r_gnt_idx  <= w_arb_idx;
            r_last_idx <= w_arb_idx;
         end else if (r_state == DONE) begin
            r_grant <= '0;
         end

         if (r_state == START) begin
            r_cnt <= '0;
         end else if ((r_state == WAIT_BUSY) && !sender_busy && !w_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (r_state == DONE) r_frames <= r_frames + 16'd1;

         r_data <= (|r_grant) ? w_sel_data : 8'h00;
      end
   end

endmodule

// File: doc/img_tx_scheduler.md
Name: img_tx_scheduler

Overview:
- Shares the single UART image sender (send_img) between NUM_SRC image buffers, e.g. SIFT pyramid/octave BRAMs.
- Latches per-source send requests and grants them round-robin, one whole image at a time.
- Pulses the sender's start input, broadcasts the sender's read address to all buffers, and returns the granted buffer's pixel through a registered mux.
- Sits between the image buffers and send_img. Reports completion per source.

Parameters:
- NUM_SRC, 4, number of image sources (2..8).
- ADDR_W, 14, BRAM address width; matches the sender's address port.
- START_TIMEOUT, 64, cycles to wait for sender_busy to rise after a start pulse before retrying.

Ports:
- clk  in  1  system clock.
- rst_in_n  in  1  asynchronous active-low reset.
- req_in  in  NUM_SRC  per-source send request; 1-cycle pulse or level, latched.
- sender_start  out  1  1-cycle pulse to the sender's img_ready.
- sender_busy  in  1  sender busy flag.
- sender_addr  in  ADDR_W  sender's BRAM read address.
- sender_data  out  8  pixel returned to the sender's data input.
- bram_addr  out  ADDR_W  address broadcast to all source BRAMs.
- bram_data  in  8*NUM_SRC  read data, source i at bits [8i+7:8i].
- grant  out  NUM_SRC  one-hot active source; all zero when idle.
- done  out  NUM_SRC  1-cycle pulse when source i's image has been fully sent.
- frames_sent  out  16  count of completed images; wraps at 65535 -> 0.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE. pending, grant, done and sender_start are 0. sender_data=0 and frames_sent=0. last_grant=NUM_SRC-1, so source 0 wins first.
- pending[i] is set on any cycle req_in[i]=1.
  - If the set coincides with that source's DONE-state clear, set wins and the source is re-queued.
  - Repeated requests while pending do not stack.
- bram_addr = sender_addr, combinational passthrough.
- sender_data is registered: sender_data <= bram_data[grant index] every cycle. The data path is BRAM latency + 1 cycle, which fits within the sender's 3-cycle pre-send wait.
- States:
  - IDLE: if pending != 0, go to ARB. Otherwise stay.
  - ARB: choose the first set pending bit scanning last_grant+1, last_grant+2, ... mod NUM_SRC. Set grant one-hot and last_grant, then go to START.
  - START: sender_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY: when sender_busy=1, go to SENDING. When the timeout counter reaches START_TIMEOUT-1, go to START (re-pulse, grant unchanged). Otherwise increment the counter.
  - SENDING: stay while sender_busy=1. When sender_busy=0, go to DONE.
  - DONE: done[granted]=1 for one cycle, clear pending[granted] (subject to the set-wins rule above), increment frames_sent, set grant=0, go to IDLE.
- Latencies:
  - req_in to sender_start is 3 cycles from idle (latch, IDLE->ARB, ARB->START).
  - Back-to-back images: at least 3 idle cycles between busy fall and the next start pulse.
- grant is held constant from ARB through DONE. Requests arriving mid-image only set pending and never preempt.
- The round-robin is fair: with all sources requesting continuously, the grant order is 0,1,..,NUM_SRC-1,0,...
- sender_busy high while in IDLE or ARB (stale sender activity) is ignored; no start is issued until the state reaches START.
- Reset mid-image: all state clears immediately and pending requests are lost. The sender must be reset by the same reset event.
- done is never asserted for a source whose image was not sent.

Decomposition:
- Shared package (img_tx_pkg): state enum sched_state {IDLE, ARB, START, WAIT_BUSY, SENDING, DONE} and the default ADDR_W constant.
- One sub-module: rr_arbiter (inputs: request vector, last index; outputs: one-hot grant, index, any). It is purely combinational.
- The scheduler holds the FSM, pending register, data mux and counters.

Test Plan:
1. Reset, then req_in=4'b0001 pulse -> sender_start pulses 3 cycles later, grant=0001. The bench model raises busy for 100 cycles, then done=0001 for one cycle and frames_sent=1.
2. req_in=4'b1111 in one cycle -> grants in order 0001, 0010, 0100, 1000, each with one done pulse; frames_sent=4; exactly 4 start pulses.
3. Source 2 granted, with bram_data for source 2 = 8'hA5 and other sources 8'h00 -> sender_data=8'hA5 one cycle later. bram_addr follows sender_addr (e.g. 14'h1234) the same cycle.
4. Sender model never raises busy -> sender_start repeats every START_TIMEOUT+1 cycles with grant unchanged and no done pulse.
5. req_in[1] re-asserted in the DONE cycle of source 1 -> pending[1] stays 1 and source 1 is sent again after any other pending source.
6. Drop rst_in_n mid-SENDING -> grant=0, pending=0 and sender_start=0 asynchronously; state returns to IDLE and frames_sent=0.
